dec_scan_ctrl: RTL and testbench

//  Parametrised registered N-to-2^N one-hot decoder with two modes:
//  - DIRECT: decodes addresses supplied over a valid/ready handshake.
//  - SCAN: an internal sequencer steps through addresses 0..last_addr, holding

---
 rtl/dec_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_dec_scan_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dec_scan_ctrl.sv
// Registered one-hot decoder with handshaked DIRECT mode and a dwell-timed SCAN sequencer.
// Optional macro DEC_BLANK_EN inserts a one-cycle all-zero blank on every scan step.
module dec_scan_ctrl #(
    parameter int   ADDR_W  = 5,
    parameter int   DWELL_W = 8,
    localparam int  OUT_W   = 1 << ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [ADDR_W-1:0]  addr_in,
    input  logic               addr_vld,
    output logic               addr_rdy,
    input  logic [ADDR_W-1:0]  last_addr,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   dec_out,
    output logic [ADDR_W-1:0]  cur_addr,
    output logic               step_pulse,
    output logic               wrap_pulse
);

    localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DIRECT     = 2'd1,
`ifdef DEC_BLANK_EN
        ST_SCAN_BLANK = 2'd3,
`endif
        ST_SCAN_HOLD  = 2'd2
    } state_t;

    state_t             state_r;
    logic [DWELL_W-1:0] cnt_r;
    logic [ADDR_W-1:0]  next_addr_s;
    logic               wrap_s;
`ifdef DEC_BLANK_EN
    logic               wrap_pend_r;
`endif

    function automatic logic [OUT_W-1:0] onehot(input logic [ADDR_W-1:0] a);
        onehot = {{(OUT_W-1){1'b0}}, 1'b1} << a;
    endfunction

    // Next scan address; >= also catches last_addr lowered below cur_addr mid-scan.
    always_comb begin
        wrap_s = (cur_addr >= last_addr);
        if (wrap_s) begin
            next_addr_s = '0;
        end else begin
            next_addr_s = cur_addr + ADDR_ONE;
        end
    end

    // Mode FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            dec_out    <= '0;
            cur_addr   <= '0;
            addr_rdy   <= 1'b0;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
`ifdef DEC_BLANK_EN
            wrap_pend_r <= 1'b0;
`endif
        end else begin
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            if (!en) begin
                state_r  <= ST_IDLE;
                dec_out  <= '0;
                addr_rdy <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (mode) begin
                            state_r    <= ST_SCAN_HOLD;
                            cur_addr   <= '0;
                            dec_out    <= onehot('0);
                            cnt_r      <= dwell;
                            step_pulse <= 1'b1;
                            addr_rdy   <= 1'b0;
                        end else begin
                            state_r  <= ST_DIRECT;
                            dec_out  <= '0;
                            addr_rdy <= 1'b1;
                        end
                    end
                    ST_DIRECT: begin
                        if (mode) begin
                            state_r  <= ST_IDLE;
                            dec_out  <= '0;
                            addr_rdy <= 1'b0;
                        end else begin
                            addr_rdy <= 1'b1;
                            if (addr_vld && addr_rdy) begin
                                dec_out  <= onehot(addr_in);
                                cur_addr <= addr_in;
                            end else begin
                                dec_out  <= dec_out;
                            end
                        end
                    end
                    ST_SCAN_HOLD: begin
                        if (!mode) begin
                            state_r  <= ST_IDLE;
                            dec_out  <= '0;
                            addr_rdy <= 1'b0;
                        end else if (cnt_r == '0) begin
                            cur_addr <= next_addr_s;
                            cnt_r    <= dwell;
`ifdef DEC_BLANK_EN
                            state_r     <= ST_SCAN_BLANK;
                            dec_out     <= '0;
                            wrap_pend_r <= wrap_s;
`else
                            dec_out    <= onehot(next_addr_s);
                            step_pulse <= 1'b1;
                            wrap_pulse <= wrap_s;
`endif
                        end else begin
                            cnt_r <= cnt_r - DWELL_ONE;
                        end
                    end
`ifdef DEC_BLANK_EN
                    // Blank cycle: cur_addr already advanced, select lights on the next edge.
                    ST_SCAN_BLANK: begin
                        if (!mode) begin
                            state_r  <= ST_IDLE;
                            dec_out  <= '0;
                            addr_rdy <= 1'b0;
                        end else begin
                            state_r    <= ST_SCAN_HOLD;
                            dec_out    <= onehot(cur_addr);
                            step_pulse <= 1'b1;
                            wrap_pulse <= wrap_pend_r;
                        end
                    end
`endif
                    default: begin
                        state_r  <= ST_IDLE;
                        dec_out  <= '0;
                        addr_rdy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Scoreboard bench for dec_scan_ctrl: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_dec_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [4:0]  addr_in;
    logic        addr_vld;
    logic        addr_rdy;
    logic [4:0]  last_addr;
    logic [7:0]  dwell;
    logic [31:0] dec_out;
    logic [4:0]  cur_addr;
    logic        step_pulse;
    logic        wrap_pulse;

    typedef struct packed {
        logic [31:0] dec;
        logic [4:0]  cur;
        logic        rdy;
        logic        stp;
        logic        wrp;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] seq_q[$];
    exp_t       got_e;
    int         n_vec = 0;
    int         n_err = 0;

    dec_scan_ctrl #(.ADDR_W(5), .DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .addr_in    (addr_in),
        .addr_vld   (addr_vld),
        .addr_rdy   (addr_rdy),
        .last_addr  (last_addr),
        .dwell      (dwell),
        .dec_out    (dec_out),
        .cur_addr   (cur_addr),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] d, input logic [4:0] c,
                                input logic r, input logic s, input logic w);
        exp_t e;
        e.dec = d;
        e.cur = c;
        e.rdy = r;
        e.stp = s;
        e.wrp = w;
        return e;
    endfunction

    // Scan code: bit7 select lit, bit6 step, bit5 wrap, bits4:0 cur_addr.
    function automatic exp_t sc(input logic [7:0] code);
        logic [31:0] one;
        one = 32'd1;
        return mk(code[7] ? (one << code[4:0]) : 32'd0, code[4:0], 1'b0, code[6], code[5]);
    endfunction

    task automatic cyc(input exp_t e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_seq();
        foreach (seq_q[i]) cyc(sc(seq_q[i]));
    endtask

    // Monitor: one expectation per clock, compared just after the edge.
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            got_e = exp_q.pop_front();
            n_vec++;
            if ({dec_out, cur_addr, addr_rdy, step_pulse, wrap_pulse} !==
                {got_e.dec, got_e.cur, got_e.rdy, got_e.stp, got_e.wrp}) begin
                n_err++;
                $display("FAIL vec%0d: got dec_out=%h cur_addr=%0d rdy=%b step=%b wrap=%b, expected dec_out=%h cur_addr=%0d rdy=%b step=%b wrap=%b",
                         n_vec, dec_out, cur_addr, addr_rdy, step_pulse, wrap_pulse,
                         got_e.dec, got_e.cur, got_e.rdy, got_e.stp, got_e.wrp);
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; addr_in = 5'd0; addr_vld = 1'b0;
        last_addr = 5'd3; dwell = 8'd1;
        repeat (3) cyc(mk(32'd0, 5'd0, 1'b0, 1'b0, 1'b0));

        // SCAN last=3 dwell=1, addr_vld asserted but ignored
        rst_n = 1'b1; addr_vld = 1'b1; addr_in = 5'd9;
`ifdef DEC_BLANK_EN
        seq_q = '{8'hC0, 8'h80, 8'h01, 8'hC1, 8'h81, 8'h02, 8'hC2, 8'h82,
                  8'h03, 8'hC3, 8'h83, 8'h00, 8'hE0, 8'h80, 8'h01};
`else
        seq_q = '{8'hC0, 8'h80, 8'hC1, 8'h81, 8'hC2, 8'h82, 8'hC3, 8'h83,
                  8'hE0, 8'h80, 8'hC1};
`endif
        run_seq();
        en = 1'b0;
        cyc(mk(32'd0, 5'd1, 1'b0, 1'b0, 1'b0));

        // SCAN last=7 dwell=0, lower last_addr to 2 at cur_addr=6
        en = 1'b1; last_addr = 5'd7; dwell = 8'd0;
`ifdef DEC_BLANK_EN
        seq_q = '{8'hC0, 8'h01, 8'hC1, 8'h02, 8'hC2, 8'h03, 8'hC3,
                  8'h04, 8'hC4, 8'h05, 8'hC5, 8'h06, 8'hC6};
`else
        seq_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
`endif
        run_seq();
        last_addr = 5'd2;
`ifdef DEC_BLANK_EN
        cyc(sc(8'h00));
`endif
        cyc(sc(8'hE0));

        // en dropped at cur_addr=5, re-enabled, then reset mid-scan
        last_addr = 5'd7;
`ifdef DEC_BLANK_EN
        seq_q = '{8'h01, 8'hC1, 8'h02, 8'hC2, 8'h03, 8'hC3, 8'h04, 8'hC4, 8'h05, 8'hC5};
`else
        seq_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
`endif
        run_seq();
        en = 1'b0;
        cyc(mk(32'd0, 5'd5, 1'b0, 1'b0, 1'b0));
        en = 1'b1;
        cyc(sc(8'hC0));
`ifdef DEC_BLANK_EN
        cyc(sc(8'h01));
`endif
        cyc(sc(8'hC1));
        rst_n = 1'b0;
        cyc(mk(32'd0, 5'd0, 1'b0, 1'b0, 1'b0));

        // DIRECT: entry cycle has no transfer even with addr_vld high
        rst_n = 1'b1; mode = 1'b0; addr_in = 5'd19; addr_vld = 1'b1;
        cyc(mk(32'd0, 5'd0, 1'b1, 1'b0, 1'b0));
        cyc(mk(32'h0008_0000, 5'd19, 1'b1, 1'b0, 1'b0));
        addr_vld = 1'b0; addr_in = 5'd3;
        repeat (2) cyc(mk(32'h0008_0000, 5'd19, 1'b1, 1'b0, 1'b0));
        addr_vld = 1'b1; addr_in = 5'd0;
        cyc(mk(32'h0000_0001, 5'd0, 1'b1, 1'b0, 1'b0));
        addr_in = 5'd31;
        cyc(mk(32'h8000_0000, 5'd31, 1'b1, 1'b0, 1'b0));

        // DIRECT -> SCAN through one IDLE cycle, last=1 dwell=0
        addr_vld = 1'b0; mode = 1'b1; last_addr = 5'd1; dwell = 8'd0;
        cyc(mk(32'd0, 5'd31, 1'b0, 1'b0, 1'b0));
`ifdef DEC_BLANK_EN
        seq_q = '{8'hC0, 8'h01, 8'hC1, 8'h00, 8'hE0, 8'h01, 8'hC1};
`else
        seq_q = '{8'hC0, 8'hC1, 8'hE0, 8'hC1};
`endif
        run_seq();

        // last=0: address 0 held, step+wrap every period
        last_addr = 5'd0; dwell = 8'd1;
`ifdef DEC_BLANK_EN
        seq_q = '{8'h00, 8'hE0, 8'h80, 8'h00, 8'hE0};
`else
        seq_q = '{8'hE0, 8'h80, 8'hE0, 8'h80};
`endif
        run_seq();

        // SCAN -> DIRECT through IDLE, then disable
        mode = 1'b0;
        cyc(mk(32'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        cyc(mk(32'd0, 5'd0, 1'b1, 1'b0, 1'b0));
        en = 1'b0;
        cyc(mk(32'd0, 5'd0, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
